// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : control_multiciclo
// Brief    : Moore control FSM for a multicycle MIPS subset (R-type, lw, sw,
//            beq, addi). Optional memory-ready handshake via macro MEM_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module control_multiciclo (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       zflag,
`ifdef MEM_WAIT_EN
   input  logic       mem_listo,
`endif
   output logic       pcen,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alop,
   output logic       pcsrc,
   output logic       fin,
   output logic       ilegal,
   output logic [3:0] estado
);

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RTWB   = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10
   } state_t;

   state_t r_state;
   state_t w_next;

   logic       w_mem_ok;
   logic       w_pcen, w_iord, w_memread, w_memwrite, w_irwrite;
   logic       w_regdst, w_memreg, w_regwrite, w_alusrca, w_pcsrc;
   logic       w_fin, w_ilegal;
   logic [1:0] w_alusrcb;
   logic [2:0] w_alop;

`ifdef MEM_WAIT_EN
   assign w_mem_ok = mem_listo;
`else
   assign w_mem_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = S_FETCH;
      w_pcen     = 1'b0;
      w_iord     = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regdst   = 1'b0;
      w_memreg   = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_alop     = 3'b000;
      w_pcsrc    = 1'b0;
      w_fin      = 1'b0;
      w_ilegal   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_memread = 1'b1;
            w_irwrite = w_mem_ok;
            w_pcen    = w_mem_ok;
            w_alusrcb = 2'b01;
            w_next    = w_mem_ok ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is precomputed here while the opcode is decoded
            w_alusrcb = 2'b11;
            case (op)
               c_OP_RTYPE:       w_next = S_EXEC;
               c_OP_LW, c_OP_SW: w_next = S_MEMADR;
               c_OP_BEQ:         w_next = S_BRANCH;
               c_OP_ADDI:        w_next = S_ADDIEX;
               default: begin
                  w_next   = S_FETCH;
                  w_ilegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_next    = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_memread = 1'b1;
            w_iord    = 1'b1;
            w_next    = w_mem_ok ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            w_regwrite = 1'b1;
            w_memreg   = 1'b1;
            w_fin      = 1'b1;
         end
         S_MEMWR: begin
            w_memwrite = 1'b1;
            w_iord     = 1'b1;
            w_fin      = w_mem_ok;
            w_next     = w_mem_ok ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            w_alusrca = 1'b1;
            w_alop    = 3'b010;
            w_next    = S_RTWB;
         end
         S_RTWB: begin
            w_regwrite = 1'b1;
            w_regdst   = 1'b1;
            w_fin      = 1'b1;
         end
         S_BRANCH: begin
            w_alusrca = 1'b1;
            w_alop    = 3'b001;
            w_pcsrc   = 1'b1;
            w_pcen    = zflag;
            w_fin     = 1'b1;
         end
         S_ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
            w_fin      = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Strobes are masked while reset is held so nothing fires mid-reset
   assign pcen     = w_pcen     & ~rst;
   assign memread  = w_memread  & ~rst;
   assign memwrite = w_memwrite & ~rst;
   assign irwrite  = w_irwrite  & ~rst;
   assign regwrite = w_regwrite & ~rst;
   assign fin      = w_fin      & ~rst;
   assign ilegal   = w_ilegal   & ~rst;
   assign iord     = w_iord;
   assign regdst   = w_regdst;
   assign memreg   = w_memreg;
   assign alusrca  = w_alusrca;
   assign alusrcb  = w_alusrcb;
   assign alop     = w_alop;
   assign pcsrc    = w_pcsrc;
   assign estado   = rst ? 4'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// Directed self-checking bench for control_multiciclo: instruction sequences,
// illegal opcode, mid-instruction reset and (with MEM_WAIT_EN) memory stalls.
module tb_control_multiciclo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic       zflag = 1'b0;
`ifdef MEM_WAIT_EN
   logic       mem_listo = 1'b1;
`endif
   logic       pcen, iord, memread, memwrite, irwrite, regdst, memreg, regwrite;
   logic       alusrca, pcsrc, fin, ilegal;
   logic [1:0] alusrcb;
   logic [2:0] alop;
   logic [3:0] estado;

   int total = 0;
   int bad = 0;

   control_multiciclo dut (
      .clk(clk), .rst(rst), .op(op), .zflag(zflag),
`ifdef MEM_WAIT_EN
      .mem_listo(mem_listo),
`endif
      .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memreg(memreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .alop(alop), .pcsrc(pcsrc),
      .fin(fin), .ilegal(ilegal), .estado(estado)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (estado !== 4'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", estado); end
      total++; if ({pcen, memread, memwrite, irwrite, regwrite, fin, ilegal} !== 7'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 0000000", {pcen, memread, memwrite, irwrite, regwrite, fin, ilegal}); end
      rst = 1'b0;
      #1;
      total++; if (estado !== 4'd0) begin bad++; $display("FAIL post_reset_estado: got %0d want 0", estado); end
      total++; if ({memread, irwrite, pcen, alusrcb} !== 5'b11101) begin
         bad++; $display("FAIL post_reset_fetch: got %b want 11101", {memread, irwrite, pcen, alusrcb}); end
   endtask

   task automatic test_rtype();
      int exp_st[5] = '{0, 1, 6, 7, 0};
      int fins = 0;
      op = 6'b000000; zflag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL rtype_estado[%0d]: got %0d want %0d", i, estado, exp_st[i]); end
         total++; if ({regwrite, regdst} !== ((exp_st[i] == 7) ? 2'b11 : (exp_st[i] == 1 ? 2'b00 : {1'b0, regdst}))) begin
            bad++; $display("FAIL rtype_regwrite[%0d]: got %b", i, {regwrite, regdst}); end
         if (i < 4 && fin === 1'b1) fins++;
         if (i == 2 && op == 6'b000000) op = 6'b111111;  // op changes in EXEC must be ignored
         if (i < 4) step();
      end
      total++; if (fins != 1) begin bad++; $display("FAIL rtype_fin_count: got %0d want 1", fins); end
      total++; if (alop !== 3'b000 || alusrcb !== 2'b01) begin bad++; $display("FAIL fetch_alu: got %b/%b want 000/01", alop, alusrcb); end
   endtask

   task automatic test_lw();
      int exp_st[6] = '{0, 1, 2, 3, 4, 0};
      op = 6'b100011;
      for (int i = 0; i < 6; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL lw_estado[%0d]: got %0d want %0d", i, estado, exp_st[i]); end
         total++; if (memread !== ((exp_st[i] == 0 || exp_st[i] == 3) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL lw_memread[%0d]: got %b", i, memread); end
         total++; if ({regwrite, memreg} !== ((exp_st[i] == 4) ? 2'b11 : 2'b00)) begin
            bad++; $display("FAIL lw_regwrite[%0d]: got %b", i, {regwrite, memreg}); end
         if (exp_st[i] == 3) begin
            total++; if (iord !== 1'b1) begin bad++; $display("FAIL lw_iord: got %b want 1", iord); end
         end
         if (exp_st[i] == 2) begin
            total++; if ({alusrca, alusrcb} !== 3'b110) begin bad++; $display("FAIL memadr_alu: got %b want 110", {alusrca, alusrcb}); end
         end
         if (i < 5) step();
      end
   endtask

   task automatic test_sw();
      int exp_st[5] = '{0, 1, 2, 5, 0};
      op = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL sw_estado[%0d]: got %0d want %0d", i, estado, exp_st[i]); end
         total++; if ({memwrite, regwrite} !== ((exp_st[i] == 5) ? 2'b10 : 2'b00)) begin
            bad++; $display("FAIL sw_memwrite[%0d]: got %b", i, {memwrite, regwrite}); end
         if (i == 1) begin
            total++; if (alusrcb !== 2'b11) begin bad++; $display("FAIL decode_alusrcb: got %b want 11", alusrcb); end
         end
         if (i < 4) step();
      end
   endtask

   task automatic test_beq(input logic z);
      int exp_st[4] = '{0, 1, 8, 0};
      op = 6'b000100; zflag = z;
      for (int i = 0; i < 4; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL beq%0d_estado[%0d]: got %0d want %0d", z, i, estado, exp_st[i]); end
         if (i == 2) begin
            total++; if ({pcen, pcsrc, fin, alop} !== {z, 5'b11001}) begin
               bad++; $display("FAIL beq%0d_branch: got %b want %b", z, {pcen, pcsrc, fin, alop}, {z, 5'b11001}); end
         end
         if (i < 3) step();
      end
      zflag = 1'b0;
   endtask

   task automatic test_addi();
      int exp_st[5] = '{0, 1, 9, 10, 0};
      op = 6'b001000;
      for (int i = 0; i < 5; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL addi_estado[%0d]: got %0d want %0d", i, estado, exp_st[i]); end
         if (i == 3) begin
            total++; if ({regwrite, regdst, memreg, fin} !== 4'b1001) begin
               bad++; $display("FAIL addi_wb: got %b want 1001", {regwrite, regdst, memreg, fin}); end
         end
         if (i < 4) step();
      end
   endtask

   task automatic test_illegal();
      int exp_st[3] = '{0, 1, 0};
      op = 6'b111111;
      for (int i = 0; i < 3; i++) begin
         total++; if (estado !== exp_st[i][3:0]) begin bad++; $display("FAIL ilegal_estado[%0d]: got %0d want %0d", i, estado, exp_st[i]); end
         total++; if ({ilegal, regwrite, memwrite} !== ((i == 1) ? 3'b100 : 3'b000)) begin
            bad++; $display("FAIL ilegal_flags[%0d]: got %b", i, {ilegal, regwrite, memwrite}); end
         if (i < 2) step();
      end
   endtask

   task automatic test_reset_mid();
      op = 6'b100011;
      step(); step(); step();
      total++; if (estado !== 4'd3) begin bad++; $display("FAIL rstmid_reach: got %0d want 3", estado); end
      rst = 1'b1;
      #1;
      total++; if ({estado, memread, irwrite, pcen, memwrite, regwrite, fin} !== 10'b0) begin
         bad++; $display("FAIL rstmid_gated: got %b want 0", {estado, memread, irwrite, pcen, memwrite, regwrite, fin}); end
      step();
      rst = 1'b0;
      #1;
      total++; if ({estado, memread, irwrite} !== 6'b000011) begin
         bad++; $display("FAIL rstmid_fetch: got %b want 000011", {estado, memread, irwrite}); end
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_mem_wait();
      int cycles = 1;
      op = 6'b100011;
      mem_listo = 1'b0;
      #1;
      total++; if ({memread, pcen, irwrite} !== 3'b100) begin bad++; $display("FAIL wait_fetch_hold: got %b want 100", {memread, pcen, irwrite}); end
      step();
      total++; if (estado !== 4'd0) begin bad++; $display("FAIL wait_fetch_stay: got %0d want 0", estado); end
      mem_listo = 1'b1;
      #1;
      total++; if ({pcen, irwrite} !== 2'b11) begin bad++; $display("FAIL wait_fetch_go: got %b want 11", {pcen, irwrite}); end
      step(); step(); step();
      cycles = 0;
      mem_listo = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_listo = 1'b1;
         #1;
         total++; if ({estado, memread} !== 5'b00111) begin bad++; $display("FAIL wait_memrd[%0d]: got %b want 00111", i, {estado, memread}); end
         step();
         cycles++;
      end
      total++; if (estado !== 4'd4 || cycles != 4) begin bad++; $display("FAIL wait_memwb: got %0d/%0d want 4/4", estado, cycles); end
      step();
      total++; if (estado !== 4'd0) begin bad++; $display("FAIL wait_done: got %0d want 0", estado); end
   endtask
`endif

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_addi();
      test_illegal();
      test_reset_mid();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 The block SHALL have a single clock `clk` with a synchronous, active-high reset `rst`; all state SHALL update on the rising edge of `clk`.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  op  in  6  opcode, instruction[31:26], sampled from the instruction register
  zflag  in  1  ALU zero flag
  mem_listo  in  1  memory ready; present only with MEM_WAIT_EN
  pcen  out  1  PC write enable
  iord  out  1  memory address select: 0=PC, 1=ALU register
  memread  out  1  memory read strobe
  memwrite  out  1  memory write strobe
  irwrite  out  1  instruction register load
  regdst  out  1  write register select: 0=rt, 1=rd
  memreg  out  1  write data select: 0=ALU register, 1=memory data register
  regwrite  out  1  register bank write enable
  alusrca  out  1  ALU operand A: 0=PC, 1=register A
  alusrcb  out  2  ALU operand B: 00=register B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate<<2
  alop  out  3  to the ALU control: 000=add, 001=sub, 010=decode funct
  pcsrc  out  1  PC source: 0=ALU result, 1=ALU register (branch target)
  fin  out  1  one-cycle pulse in the last state of every instruction
  ilegal  out  1  one-cycle pulse on an unsupported opcode
  estado  out  4  current state code, for debug

Function
REQ-003 The block SHALL be a Moore FSM; all outputs are decoded from the registered state only, except pcen and the MEM_WAIT_EN gating.
REQ-004 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-005 Output decode per state (unlisted outputs = 0):
  - FETCH: memread=1, irwrite=1, iord=0, alusrca=0, alusrcb=01, alop=000, pcsrc=0, pcen=1.
  - DECODE: alusrca=0, alusrcb=11, alop=000 (precomputes the branch target).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, alop=000.
  - MEMRD: memread=1, iord=1.
  - MEMWR: memwrite=1, iord=1, fin=1.
  - MEMWB: regwrite=1, regdst=0, memreg=1, fin=1.
  - EXEC: alusrca=1, alusrcb=00, alop=010.
  - RTWB: regwrite=1, regdst=1, memreg=0, fin=1.
  - ADDIWB: regwrite=1, regdst=0, memreg=0, fin=1.
  - BRANCH: alusrca=1, alusrcb=00, alop=001, pcsrc=1, pcen=zflag, fin=1.
REQ-006 Transitions: FETCH->DECODE always; from DECODE by op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - any other op -> FETCH, with ilegal=1 in that DECODE cycle.
REQ-007 Remaining transitions: MEMADR->MEMRD if op=100011, else ->MEMWR; MEMRD->MEMWB; EXEC->RTWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTWB, ADDIWB and BRANCH ->FETCH.
REQ-008 Cycles per instruction without MEM_WAIT_EN SHALL be: R-type 4, lw 5, sw 4, beq 3, addi 4, illegal 2.
REQ-009 op SHALL be sampled only in DECODE and MEMADR; changes of op in other states SHALL have no effect.

Reset
REQ-010 rst=1 at a rising edge SHALL set the state to FETCH regardless of the current state, including mid-instruction.
REQ-011 While rst=1, every control output (pcen, memread, memwrite, irwrite, regwrite, fin, ilegal) SHALL be forced to 0 and estado SHALL read 0.
REQ-012 The first cycle after rst falls SHALL be FETCH with FETCH outputs active.

Configuration
REQ-013 With macro MEM_WAIT_EN defined, port mem_listo SHALL exist, and FETCH, MEMRD and MEMWR SHALL hold until mem_listo=1. While holding: memread/memwrite stay asserted; pcen, irwrite and fin are gated to 0; in FETCH, pcen and irwrite assert only in the cycle mem_listo=1.
REQ-014 Without MEM_WAIT_EN, port mem_listo SHALL be absent and each memory state SHALL last exactly one cycle.

Verification
REQ-015 Reset, then op=000000, zflag=0 -> estado 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7; fin pulses once.
REQ-016 op=100011 -> estado 0,1,2,3,4,0; memread=1 in states 0 and 3; regwrite with memreg=1 in state 4. op=101011 -> estado 0,1,2,5,0 with memwrite=1 only in state 5.
REQ-017 op=000100 with zflag=1 -> pcen=1, pcsrc=1 in state 8. With zflag=0 -> pcen=0 in state 8. Both cases return to state 0 after 3 cycles.
REQ-018 op=111111 -> estado 0,1,0; ilegal=1 for exactly the DECODE cycle; no regwrite or memwrite.
REQ-019 rst asserted for one cycle while in MEMRD -> all strobes 0 during the reset cycle, then estado=0 with memread=1 and irwrite=1.
REQ-020 With MEM_WAIT_EN and op=100011, mem_listo held low 3 cycles in MEMRD -> estado stays 3 for 4 cycles with memread=1, then moves to 4; lw total is 8 cycles.
